gpio_cmd_receiver: RTL and testbench

// - PS-side end of the 32-bit GPIO command bus: decodes {w_clk, data[7:0], addr[15:0]} strobes into write and read requests for the experiment fabric.
// - Pairs two byte writes to the same address into one 16-bit register write, passes single-byte control writes through, services read triggers, returns data on gpio_out_bus.
// - Sits between the AXI GPIO block and the lookup-table, A/C memory and experiment FSM register decoders.

---
 rtl/gpio_cmd_receiver_pkg.sv | 17 +
 rtl/gpio_strobe_sync.sv | 17 +
 rtl/gpio_cmd_receiver.sv | 130 +++++++++++++
 tb/tb_gpio_cmd_receiver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cmd_receiver_pkg.sv
// Shared constants for the GPIO command receiver: address map defaults, bus field layout, FSM encodings.
package gpio_cmd_receiver_pkg;
   localparam logic [15:0] RD_BASE_DEF    = 16'h0080;
   localparam logic [15:0] PAIR_BASE_DEF  = 16'h0100;
   localparam int          RD_TIMEOUT_DEF = 64;

   localparam int ADDR_LSB = 0;
   localparam int ADDR_W   = 16;
   localparam int DATA_LSB = 16;
   localparam int DATA_W   = 8;
   localparam int WCLK_BIT = 24;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t ST_IDLE    = 2'd0;
   localparam rx_state_t ST_HAVE_HI = 2'd1;
   localparam rx_state_t ST_RD_WAIT = 2'd2;
endpackage

// File: rtl/gpio_strobe_sync.sv
// Brings an asynchronous GPIO strobe into clk with a 2-FF synchronizer; pulses one cycle per rising edge.
// Strobe appears 2 clk edges after the async rise; no backpressure.
module gpio_strobe_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic strobe
);
   logic [2:0] sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync <= 3'b000;
      else      sync <= {sync[1:0], async_in};
   end

   assign strobe = sync[1] & ~sync[2];
endmodule

// File: rtl/gpio_cmd_receiver.sv
// Decodes GPIO command strobes into paired/single register writes and read requests; read data returned on gpio_out_bus.
// Latency w_clk rise -> wr_valid is 3-4 clk; rd_req holds until rd_ack or timeout. Optional counters: GPIO_RX_STATS_EN.
module gpio_cmd_receiver
   import gpio_cmd_receiver_pkg::*;
#(
   parameter logic [15:0] RD_BASE    = RD_BASE_DEF,
   parameter logic [15:0] PAIR_BASE  = PAIR_BASE_DEF,
   parameter int          RD_TIMEOUT = RD_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out_bus,
   output logic        wr_valid,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic        rd_ack,
   input  logic [15:0] rd_data,
   output logic [31:0] stat_bus
);
   localparam int TW = $clog2(RD_TIMEOUT);

   rx_state_t        state;
   logic [15:0]      hi_addr;
   logic [7:0]       hi_data;
   logic [TW-1:0]    rd_timer;
   logic             strobe;
   logic [15:0]      addr;
   logic [7:0]       data;
   logic             pair_hit;
   logic             idle_like;
   logic             pair_err;
   logic             timeout;
   logic             unused_bits;

   gpio_strobe_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (gpio_in[WCLK_BIT]),
      .strobe   (strobe)
   );

   // The host holds addr/data stable well before w_clk rises, so the raw bus is safe to sample on the strobe cycle.
   assign addr        = gpio_in[ADDR_LSB +: ADDR_W];
   assign data        = gpio_in[DATA_LSB +: DATA_W];
   assign unused_bits = ^gpio_in[31:25];

   assign pair_hit  = strobe && (state == ST_HAVE_HI) && (addr == hi_addr);
   // A mismatched second byte abandons the held half and is decoded afresh as if from IDLE.
   assign idle_like = strobe && ((state == ST_IDLE) || ((state == ST_HAVE_HI) && (addr != hi_addr)));
   assign pair_err  = strobe && (((state == ST_HAVE_HI) && (addr != hi_addr)) || (state == ST_RD_WAIT));
   assign timeout   = (rd_timer == TW'(RD_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         hi_addr      <= '0;
         hi_data      <= '0;
         rd_timer     <= '0;
         wr_valid     <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         rd_req       <= 1'b0;
         rd_addr      <= '0;
         gpio_out_bus <= '0;
      end else begin
         wr_valid <= 1'b0;
         if (pair_hit) begin
            wr_valid <= 1'b1;
            wr_addr  <= hi_addr;
            wr_data  <= {hi_data, data};
            state    <= ST_IDLE;
         end else if (idle_like) begin
            if (addr < RD_BASE) begin
               wr_valid <= 1'b1;
               wr_addr  <= addr;
               wr_data  <= {8'h00, data};
               state    <= ST_IDLE;
            end else if (addr < PAIR_BASE) begin
               rd_req   <= 1'b1;
               rd_addr  <= addr;
               rd_timer <= '0;
               state    <= ST_RD_WAIT;
            end else begin
               hi_addr  <= addr;
               hi_data  <= data;
               state    <= ST_HAVE_HI;
            end
         end else if (state == ST_RD_WAIT) begin
            // Ack is checked first so a last-cycle ack still returns data.
            if (rd_ack) begin
               gpio_out_bus <= {1'b0, 15'b0, rd_data};
               rd_req       <= 1'b0;
               state        <= ST_IDLE;
            end else if (timeout) begin
               gpio_out_bus <= {1'b1, 15'b0, 16'h0000};
               rd_req       <= 1'b0;
               state        <= ST_IDLE;
            end else begin
               rd_timer <= rd_timer + TW'(1);
            end
         end
      end
   end

`ifdef GPIO_RX_STATS_EN
   logic [15:0] strobe_cnt;
   logic [15:0] pair_err_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strobe_cnt   <= '0;
         pair_err_cnt <= '0;
      end else begin
         if (strobe && (strobe_cnt != 16'hFFFF))
            strobe_cnt <= strobe_cnt + 16'd1;
         if (pair_err && (pair_err_cnt != 16'hFFFF))
            pair_err_cnt <= pair_err_cnt + 16'd1;
      end
   end

   assign stat_bus = {pair_err_cnt, strobe_cnt};
`else
   logic unused_pair_err;
   assign unused_pair_err = pair_err;
   assign stat_bus        = 32'h0;
`endif
endmodule

// File: tb/tb_gpio_cmd_receiver.sv
// Directed bench for gpio_cmd_receiver: paired/single writes, pair errors, reads with ack/timeout, reset mid-pair.
module tb_gpio_cmd_receiver;
   logic        clk;
   logic        rst;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out_bus;
   logic        wr_valid;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        rd_req;
   logic [15:0] rd_addr;
   logic        rd_ack;
   logic [15:0] rd_data;
   logic [31:0] stat_bus;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int wr_cyc = 0;
   int rise_cyc = 0;
   logic [15:0] last_addr = '0;
   logic [15:0] last_data = '0;

   gpio_cmd_receiver dut (
      .clk          (clk),
      .rst          (rst),
      .gpio_in      (gpio_in),
      .gpio_out_bus (gpio_out_bus),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_ack       (rd_ack),
      .rd_data      (rd_data),
      .stat_bus     (stat_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_valid) begin
         wr_cnt    <= wr_cnt + 1;
         wr_cyc    <= cyc;
         last_addr <= wr_addr;
         last_data <= wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
      end
   endtask

   task automatic put_bus(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      gpio_in[23:0] = {d, a};
      repeat (2) @(negedge clk);
   endtask

   task automatic wclk(input logic lvl);
      gpio_in[24] = lvl;
      if (lvl) rise_cyc = cyc;
   endtask

   task automatic send(input logic [15:0] a, input logic [7:0] d);
      put_bus(a, d);
      wclk(1'b1);
      repeat (6) @(negedge clk);
      wclk(1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   int base;
   bit ok;

   initial begin
      gpio_in = '0;
      rd_ack  = 1'b0;
      rd_data = '0;
      rst     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
      check("rst_rd_req", {31'b0, rd_req}, 32'd0);
      check("rst_gpio_out", gpio_out_bus, 32'h0);
      check("rst_wr_data", {16'b0, wr_data}, 32'h0);
      check("rst_stat", stat_bus, 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Paired write
      base = wr_cnt;
      send(16'h0105, 8'h12);
      check("pair_first_none", wr_cnt - base, 0);
      send(16'h0105, 8'h34);
      check("pair_one_wr", wr_cnt - base, 1);
      check("pair_addr", {16'b0, last_addr}, 32'h0105);
      check("pair_data", {16'b0, last_data}, 32'h1234);

      // Single-byte write and its latency
      base = wr_cnt;
      send(16'h0010, 8'h01);
      check("single_wr", wr_cnt - base, 1);
      check("single_addr", {16'b0, last_addr}, 32'h0010);
      check("single_data", {16'b0, last_data}, 32'h0001);
      check("single_lat_le4", {31'b0, ((wr_cyc - rise_cyc) <= 4) && ((wr_cyc - rise_cyc) >= 1)}, 32'd1);

      // Pair error then re-pair on the new address
      base = wr_cnt;
      send(16'h0105, 8'hAA);
      send(16'h0106, 8'h55);
      check("perr_no_wr", wr_cnt - base, 0);
      send(16'h0106, 8'h66);
      check("perr_repair_wr", wr_cnt - base, 1);
      check("perr_addr", {16'b0, last_addr}, 32'h0106);
      check("perr_data", {16'b0, last_data}, 32'h5566);

      // Read with ack after 3 cycles
      put_bus(16'h0081, 8'h00);
      wclk(1'b1);
      wait_rd(ok);
      check("rd_req_rise", {31'b0, ok}, 32'd1);
      check("rd_addr", {16'b0, rd_addr}, 32'h0081);
      repeat (3) @(negedge clk);
      check("rd_req_hold", {31'b0, rd_req}, 32'd1);
      rd_ack  = 1'b1;
      rd_data = 16'hBEEF;
      @(negedge clk);
      rd_ack  = 1'b0;
      check("rd_ack_req_drop", {31'b0, rd_req}, 32'd0);
      check("rd_ack_data", gpio_out_bus, 32'h0000BEEF);
      wclk(1'b0);
      repeat (3) @(negedge clk);

      // Read timeout after exactly 64 cycles
      put_bus(16'h0081, 8'h00);
      wclk(1'b1);
      wait_rd(ok);
      check("to_req_rise", {31'b0, ok}, 32'd1);
      repeat (63) @(negedge clk);
      check("to_req_63", {31'b0, rd_req}, 32'd1);
      @(negedge clk);
      check("to_req_64", {31'b0, rd_req}, 32'd0);
      check("to_gpio_out", gpio_out_bus, 32'h80000000);
      wclk(1'b0);
      repeat (3) @(negedge clk);
      base = wr_cnt;
      send(16'h0020, 8'h7F);
      check("to_idle_wr", wr_cnt - base, 1);
      check("to_idle_data", {16'b0, last_data}, 32'h007F);
      check("wr_keeps_gpio_out", gpio_out_bus, 32'h80000000);

      // Strobe during RD_WAIT is dropped
      put_bus(16'h0090, 8'h00);
      wclk(1'b1);
      wait_rd(ok);
      check("rdw_req_rise", {31'b0, ok}, 32'd1);
      wclk(1'b0);
      base = wr_cnt;
      put_bus(16'h0010, 8'h55);
      wclk(1'b1);
      repeat (5) @(negedge clk);
      check("rdw_drop_no_wr", wr_cnt - base, 0);
      check("rdw_req_still", {31'b0, rd_req}, 32'd1);
      rd_ack  = 1'b1;
      rd_data = 16'h1234;
      @(negedge clk);
      rd_ack  = 1'b0;
      check("rdw_ack_data", gpio_out_bus, 32'h00001234);
      wclk(1'b0);
      repeat (3) @(negedge clk);

      // Reset in HAVE_HI discards the held byte
      send(16'h0105, 8'h11);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_gpio_out", gpio_out_bus, 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      base = wr_cnt;
      send(16'h0105, 8'h22);
      check("post_rst_no_wr", wr_cnt - base, 0);
`ifdef GPIO_RX_STATS_EN
      check("post_rst_stats", stat_bus, 32'h0000_0001);
`else
      check("post_rst_stats", stat_bus, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
